// File: rtl/noise_sample_gen.sv
// White-noise sample source: von Neumann debiased ring-oscillator bits folded into a
// 32-bit Galois LFSR, sliced, attenuated and handed to the mixer over valid/ready.
module noise_sample_gen #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468,
    parameter int unsigned STUCK_LIMIT  = 64
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    rand_bit,
    output logic                    ro_enable,
    input  logic                    sample_tick,
    input  logic [3:0]              atten,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    entropy_ok,
    output logic                    overrun
);

    localparam logic [31:0]         TapMask    = 32'h8020_0003;
    localparam int unsigned         StuckW     = $clog2(STUCK_LIMIT + 1);
    localparam logic [StuckW-1:0]   StuckMax   = StuckW'(STUCK_LIMIT);
    localparam logic [3:0]          HarvestMax = 4'd8;
    localparam logic [4:0]          ShiftMax   = 5'(SAMPLE_WIDTH - 1);

    logic                    ro_en_q;
    logic                    phase_q, phase_d;
    logic                    first_q, first_d;
    logic [31:0]             lfsr_q, lfsr_d, lfsr_step;
    logic [StuckW-1:0]       stuck_q, stuck_d;
    logic [3:0]              harvest_q, harvest_d;
    logic                    eok_q, eok_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;
    logic                    db_valid;
    logic signed [SAMPLE_WIDTH-1:0] raw;
    logic [4:0]              shamt;

    // A debiased bit exists only for an unequal pair; its value is the first bit.
    assign db_valid = enable & phase_q & (rand_bit ^ first_q);

    always_comb begin
        phase_d = 1'b0;
        first_d = first_q;
        if (enable && !phase_q) begin
            phase_d = 1'b1;
            first_d = rand_bit;
        end
    end

    always_comb begin
        lfsr_step     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TapMask : 32'h0);
        lfsr_step[31] = lfsr_step[31] ^ (db_valid & first_q);
        lfsr_d        = lfsr_q;
        if (enable) begin
            lfsr_d = (lfsr_step == 32'h0) ? LFSR_SEED : lfsr_step;
        end
    end

    always_comb begin
        stuck_d   = '0;
        harvest_d = '0;
        eok_d     = 1'b0;
        if (enable) begin
            if (db_valid) begin
                stuck_d = '0;
            end else if (stuck_q != StuckMax) begin
                stuck_d = stuck_q + 1'b1;
            end else begin
                stuck_d = stuck_q;
            end
            harvest_d = harvest_q + ((db_valid && harvest_q != HarvestMax) ? 4'd1 : 4'd0);
            eok_d     = (harvest_q == HarvestMax) && (stuck_q < StuckMax);
        end
    end

    always_comb begin
        raw      = lfsr_q[31 -: SAMPLE_WIDTH];
        shamt    = (32'(atten) > SAMPLE_WIDTH - 1) ? ShiftMax : {1'b0, atten};
        sample_d = sample_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        if (!enable) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (valid_q && sample_ready) begin
                valid_d = 1'b0;
            end
            if (sample_tick) begin
                // A stalled slot drops the tick; an accepted slot can reload same cycle.
                if (valid_q && !sample_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    sample_d = raw >>> shamt;
                    valid_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ro_en_q   <= 1'b0;
            phase_q   <= 1'b0;
            first_q   <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            stuck_q   <= '0;
            harvest_q <= '0;
            eok_q     <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            ro_en_q   <= enable;
            phase_q   <= phase_d;
            first_q   <= first_d;
            lfsr_q    <= lfsr_d;
            stuck_q   <= stuck_d;
            harvest_q <= harvest_d;
            eok_q     <= eok_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign ro_enable    = ro_en_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign entropy_ok   = eok_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_noise_sample_gen.sv
// Scoreboard bench for noise_sample_gen: expected samples are queued at stimulus time
// and popped by per-instance monitors on every valid/ready transfer.
module tb_noise_sample_gen;

    localparam int unsigned SW   = 16;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          resetn, enable, rand_bit, sample_tick, sample_ready;
    logic [3:0]    atten;
    logic          ro_enable, sample_valid, entropy_ok, overrun;
    logic [SW-1:0] sample_out;

    logic          resetn_a, enable_a, rand_a, tick_a, ready_a;
    logic [3:0]    atten_a;
    logic          ro_en_a, valid_a, eok_a, ovr_a;
    logic [SW-1:0] sample_a;

    noise_sample_gen #(.SAMPLE_WIDTH(SW), .LFSR_SEED(SEED), .STUCK_LIMIT(64)) dut (
        .CLOCK_50(clk), .resetn(resetn), .enable(enable), .rand_bit(rand_bit),
        .ro_enable(ro_enable), .sample_tick(sample_tick), .atten(atten),
        .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .entropy_ok(entropy_ok), .overrun(overrun)
    );

    noise_sample_gen #(.SAMPLE_WIDTH(SW), .LFSR_SEED(32'h8000_0000), .STUCK_LIMIT(64)) dut_att (
        .CLOCK_50(clk), .resetn(resetn_a), .enable(enable_a), .rand_bit(rand_a),
        .ro_enable(ro_en_a), .sample_tick(tick_a), .atten(atten_a),
        .sample_out(sample_a), .sample_valid(valid_a), .sample_ready(ready_a),
        .entropy_ok(eok_a), .overrun(ovr_a)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [SW-1:0] q[$];
    logic [SW-1:0] qa[$];
    logic [SW-1:0] exp_m, exp_a;

    // Reference model state
    logic [31:0] m_lfsr;
    logic        m_phase, m_first, m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [SW-1:0] exp_sample(input logic [31:0] l, input logic [3:0] a);
        logic signed [SW-1:0] r;
        r = l[31:16];
        return r >>> a;
    endfunction

    task automatic model_reset();
        m_lfsr  = SEED;
        m_phase = 1'b0;
        m_first = 1'b0;
        m_valid = 1'b0;
    endtask

    // Advance the model with the inputs currently driven, then cross one clock edge.
    task automatic step();
        logic        db, dbit;
        logic [31:0] nx;
        if (enable) begin
            db   = m_phase && (rand_bit != m_first);
            dbit = m_first;
            if (sample_tick) begin
                if (!(m_valid && !sample_ready)) begin
                    q.push_back(exp_sample(m_lfsr, atten));
                    m_valid = 1'b1;
                end
            end else if (m_valid && sample_ready) begin
                m_valid = 1'b0;
            end
            if (m_phase) begin
                m_phase = 1'b0;
            end else begin
                m_first = rand_bit;
                m_phase = 1'b1;
            end
            nx = {1'b0, m_lfsr[31:1]};
            if (m_lfsr[0]) nx = nx ^ TAPS;
            if (db) nx[31] = nx[31] ^ dbit;
            if (nx == 32'h0) nx = SEED;
            m_lfsr = nx;
        end else begin
            m_phase = 1'b0;
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (resetn && sample_valid && sample_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got %h expected no transfer", sample_out);
            end else begin
                exp_m = q.pop_front();
                if (sample_out !== exp_m) begin
                    n_bad++;
                    $display("FAIL sb_sample: got %h expected %h", sample_out, exp_m);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resetn_a && valid_a && ready_a) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_bad++;
                $display("FAIL att_unexpected: got %h expected no transfer", sample_a);
            end else begin
                exp_a = qa.pop_front();
                if (sample_a !== exp_a) begin
                    n_bad++;
                    $display("FAIL att_sample: got %h expected %h", sample_a, exp_a);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ro_enable"}, 32'(ro_enable), 32'h0);
        check({tag, "_sample_out"}, 32'(sample_out), 32'h0);
        check({tag, "_sample_valid"}, 32'(sample_valid), 32'h0);
        check({tag, "_entropy_ok"}, 32'(entropy_ok), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    // Stub source: rand_bit stuck at 0, a tick every 100 cycles, consumer always ready.
    task automatic run_stub(input string tag);
        q.delete();
        model_reset();
        enable       = 1'b1;
        rand_bit     = 1'b0;
        sample_ready = 1'b1;
        sample_tick  = 1'b0;
        atten        = 4'd0;
        resetn       = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            sample_tick = (i % 100 == 0);
            step();
            if (i % 100 == 0) check({tag, "_eok_stub"}, 32'(entropy_ok), 32'h0);
        end
        sample_tick = 1'b0;
        step();
        step();
        check({tag, "_ro_enable_on"}, 32'(ro_enable), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; enable = 1'b1; rand_bit = 1'b1; sample_tick = 1'b1;
        sample_ready = 1'b0; atten = 4'd5;
        resetn_a = 1'b0; enable_a = 1'b1; rand_a = 1'b0; tick_a = 1'b1;
        ready_a = 1'b1; atten_a = 4'd15;
        model_reset();

        // Attenuation: seed top half is 16'h8000, captured on the first enabled cycle
        @(posedge clk); #1;
        resetn_a = 1'b1;
        qa.push_back(16'hFFFF);
        @(posedge clk); #1;
        tick_a = 1'b0;
        @(posedge clk); #1;
        resetn_a = 1'b0;
        atten_a  = 4'd4;
        tick_a   = 1'b1;
        #1;
        resetn_a = 1'b1;
        qa.push_back(16'hF800);
        @(posedge clk); #1;
        tick_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("att_queue_drained", 32'(qa.size()), 32'h0);

        check_all_zero("reset");
        run_stub("run1");

        // Enable low: tick ignored, state cleared
        enable = 1'b0; sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("dis_valid", 32'(sample_valid), 32'h0);
        check("dis_ro_enable", 32'(ro_enable), 32'h0);
        check("dis_eok", 32'(entropy_ok), 32'h0);

        // Debiasing: alternating pairs 0,1 each yield one bit
        enable = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            rand_bit = (c % 2 == 0);
            step();
            if (c == 16) check("eok_before_8th", 32'(entropy_ok), 32'h0);
            if (c == 17) check("eok_after_8th", 32'(entropy_ok), 32'h1);
        end
        rand_bit = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            step();
            if (k == 60) check("eok_not_yet_stuck", 32'(entropy_ok), 32'h1);
            if (k == 66) check("eok_stuck", 32'(entropy_ok), 32'h0);
        end
        rand_bit = 1'b0; step();
        rand_bit = 1'b1; step();
        rand_bit = 1'b0; step();
        check("eok_recovered", 32'(entropy_ok), 32'h1);

        // Handshake: stall, drop a tick, then drain
        sample_ready = 1'b0; sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("hs_valid", 32'(sample_valid), 32'h1);
        check("hs_no_overrun", 32'(overrun), 32'h0);
        repeat (3) step();
        check("hs_valid_held", 32'(sample_valid), 32'h1);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("hs_overrun", 32'(overrun), 32'h1);
        sample_ready = 1'b1;
        step();
        check("hs_valid_drained", 32'(sample_valid), 32'h0);
        check("hs_overrun_sticky", 32'(overrun), 32'h1);

        // Simultaneous accept and reload
        enable = 1'b0;
        step();
        check("ovr_cleared", 32'(overrun), 32'h0);
        enable = 1'b1; sample_ready = 1'b0; sample_tick = 1'b1;
        step();
        sample_ready = 1'b1;
        step();
        sample_tick = 1'b0;
        check("sim_valid", 32'(sample_valid), 32'h1);
        check("sim_no_overrun", 32'(overrun), 32'h0);
        step();
        check("sim_drained", 32'(sample_valid), 32'h0);

        // Reset mid-operation with a pending sample and extractor in phase 1
        sample_ready = 1'b0; sample_tick = 1'b1; rand_bit = 1'b1;
        step();
        sample_tick = 1'b0;
        for (int k = 0; k < 4; k++) if (!m_phase) step();
        resetn = 1'b0;
        #2;
        check_all_zero("midreset");
        run_stub("run2");

        sample_tick = 1'b0;
        repeat (3) step();
        check("sb_drained", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/noise_sample_gen.md
Name: noise_sample_gen

Overview:
- Consumes the raw `rand_bit` stream from the ring-oscillator entropy source.
- Debiases it with a von Neumann extractor and folds the harvested bits into a 32-bit Galois LFSR.
- Emits attenuated, signed white-noise audio samples on the audio sample strobe through a valid/ready handshake to the mixer.
- Drives the oscillator `enable` and reports entropy health, so the block still produces noise when the source is stuck.

Parameters:
- SAMPLE_WIDTH, 16: width of the signed output sample; legal range 8..32.
- LFSR_SEED, 32'hACE1_2468: LFSR reset/recovery value; must be nonzero.
- STUCK_LIMIT, 64: consecutive enabled cycles without a debiased bit before entropy is flagged bad.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  block enable.
- rand_bit  in  1  raw entropy bit from the ring oscillator, sampled every cycle.
- ro_enable  out  1  enable to the ring oscillator.
- sample_tick  in  1  one-cycle audio-rate strobe.
- atten  in  4  arithmetic right-shift amount applied to the sample.
- sample_out  out  SAMPLE_WIDTH  signed noise sample.
- sample_valid  out  1  `sample_out` is valid.
- sample_ready  in  1  consumer accepts the sample this cycle.
- entropy_ok  out  1  entropy source healthy.
- overrun  out  1  sticky flag: a tick was dropped due to backpressure.

Behaviour:
- **Reset (async, resetn=0):**
  - Outputs: ro_enable=0, sample_out=0, sample_valid=0, entropy_ok=0, overrun=0.
  - Internal: LFSR=LFSR_SEED, extractor phase=0, stuck counter=0, harvest counter=0.
- **ro_enable:** `enable` registered by one cycle.
- **Extractor:** active only while enable=1.
  - Phase 0: capture rand_bit as `first`, go to phase 1.
  - Phase 1: if rand_bit != `first`, emit one debiased bit equal to `first` (db_valid pulse). Pairs 00 and 11 are discarded. Go to phase 0.
- **LFSR:**
  - Polynomial x^32+x^22+x^2+x+1; Galois taps mask 32'h8020_0003; shifts right.
  - Advances one step every cycle while enable=1 and holds while enable=0.
  - When db_valid=1, the debiased bit is XORed into bit 31 of the next state.
  - If the computed next state is 0, load LFSR_SEED instead.
- **Stuck counter:** while enabled, increments each cycle without db_valid, saturating at STUCK_LIMIT; clears on db_valid.
- **Harvest counter:** 4-bit, counts db_valid pulses, saturating at 8.
- **entropy_ok** (registered) = (harvest count == 8) AND (stuck count < STUCK_LIMIT). After it drops through stuck saturation, it reasserts on the next db_valid.
- **Sample capture:** on sample_tick=1 with enable=1.
  - Take raw = LFSR[31 -: SAMPLE_WIDTH] from the current-cycle state.
  - sample_out <= raw >>> min(atten, SAMPLE_WIDTH-1), arithmetic shift, sign preserved.
  - sample_valid <= 1.
  - Latency: tick in cycle N → sample_valid and sample_out updated at edge N+1.
- **Handshake:**
  - sample_out is held stable while sample_valid=1 and sample_ready=0.
  - Transfer occurs when sample_valid=1 and sample_ready=1. After a transfer with no new tick, sample_valid goes to 0.
  - tick with sample_valid=1 and sample_ready=0: tick dropped, sample_out unchanged, overrun set to 1.
  - tick with sample_valid=1 and sample_ready=1 in the same cycle: old sample accepted, new sample loaded, sample_valid stays 1, no overrun.
  - tick with enable=0: ignored.
- **enable deassert:** takes effect next cycle.
  - Cleared: sample_valid, extractor phase, stuck counter, harvest counter, entropy_ok, overrun.
  - Held: LFSR and sample_out.
- **Reset mid-operation:** all state returns to reset values immediately. Any pending sample is lost and no transfer is reported.
- **rand_bit permanently 0 (synthesis stub case):**
  - LFSR free-runs from the seed; samples are still produced.
  - entropy_ok stays 0.

Test Plan:
- Reset: hold resetn=0 with arbitrary inputs → all outputs 0. Release with enable=1, rand_bit=0, tick every 100 cycles → entropy_ok stays 0 and each sample_out matches the reference LFSR model from 32'hACE1_2468 stepped with no injection (atten=0).
- Debiasing: enable=1, rand_bit alternating 0,1,0,1 → db_valid every 2nd cycle with bit 0. entropy_ok=1 two edges after the 8th pair completes (the 16th enabled cycle). Then rand_bit=1 constant for 64 cycles → entropy_ok=0.
- Handshake: tick with sample_ready=0 → sample_valid=1 at N+1, value held. Second tick while still stalled → sample_out unchanged, overrun=1. Raise sample_ready → one transfer, then sample_valid=0.
- Simultaneous events: sample_valid=1, sample_ready=1 and tick in the same cycle → sample_valid stays 1, sample_out takes the new LFSR slice, overrun stays 0.
- Attenuation: force LFSR top bits 16'h8000 via the seed parameter, atten=15 → sample_out=16'hFFFF. atten=4 → 16'hF800.
- Reset mid-operation: assert resetn=0 while sample_valid=1 and the extractor is in phase 1 → outputs 0 asynchronously. After release the sequence restarts identically to the first test.
